// File: rtl/hazard_ctrl_sb_if.sv
// rtl/hazard_ctrl_sb_if.sv - pipeline-side signal bundle for the hazard controller
//
// Groups every non-clock/reset signal of hazard_ctrl_sb.
//   slave  : the hazard controller (reads pipeline state, drives stall/flush/forward selects)
//   master : the pipeline (drives pipeline state, observes controls)
// Pipeline inputs : rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mem_read_e, fwd_rd, fwd_we,
//                   long_issue_e, long_done, long_rd, redirect_e, mem_stall
// Controls out    : fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, sb_busy
// HAZARD_PERF_EN  : adds perf_stall_cyc, perf_lu_evt, perf_flush_evt (32b counters)
interface hazard_ctrl_sb_if #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic [REG_AW-1:0]            rs1_d;
    logic [REG_AW-1:0]            rs2_d;
    logic [REG_AW-1:0]            rs1_e;
    logic [REG_AW-1:0]            rs2_e;
    logic [REG_AW-1:0]            rd_e;
    logic                         mem_read_e;
    logic [FWD_STAGES*REG_AW-1:0] fwd_rd;
    logic [FWD_STAGES-1:0]        fwd_we;
    logic                         long_issue_e;
    logic                         long_done;
    logic [REG_AW-1:0]            long_rd;
    logic                         redirect_e;
    logic                         mem_stall;
    logic [SEL_W-1:0]             fwd_a_e;
    logic [SEL_W-1:0]             fwd_b_e;
    logic                         stall_f;
    logic                         stall_d;
    logic                         flush_d;
    logic                         flush_e;
    logic                         sb_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0]                  perf_stall_cyc;
    logic [31:0]                  perf_lu_evt;
    logic [31:0]                  perf_flush_evt;
`endif

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mem_read_e, fwd_rd, fwd_we,
               long_issue_e, long_done, long_rd, redirect_e, mem_stall,
`ifdef HAZARD_PERF_EN
        output perf_stall_cyc, perf_lu_evt, perf_flush_evt,
`endif
        output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, sb_busy
    );

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mem_read_e, fwd_rd, fwd_we,
               long_issue_e, long_done, long_rd, redirect_e, mem_stall,
`ifdef HAZARD_PERF_EN
        input  perf_stall_cyc, perf_lu_evt, perf_flush_evt,
`endif
        input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, sb_busy
    );
endinterface

// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - forwarding, load-use/scoreboard stall and redirect flush control
//
// Ports:
//   clk   : core clock
//   rst_n : synchronous reset, active low
//   hz    : hazard_ctrl_sb_if.slave bundle (pipeline state in, stall/flush/forward controls out)
// Parameters: REG_AW (register index width), FWD_STAGES (forwarding producers, 0 = youngest),
//   FLUSH_CYCLES (cycles flush_d is held after a redirect, >= 1).
// Optional feature macro: HAZARD_PERF_EN (saturating stall/load-use/redirect event counters).
module hazard_ctrl_sb #(
    parameter int REG_AW       = 5,
    parameter int FWD_STAGES   = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_ctrl_sb_if.slave hz
);
    localparam int SEL_W    = $clog2(FWD_STAGES + 1);
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [CNT_W-1:0]    flush_cnt;
    logic [CNT_W-1:0]    flush_cnt_nxt;
    logic                lu;
    logic                sb;
    logic                fw;

    // Scan oldest to youngest so the youngest matching producer is the last writer.
    always_comb begin
        hz.fwd_a_e = '0;
        hz.fwd_b_e = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hz.fwd_we[k] && hz.rs1_e != '0 && hz.fwd_rd[k*REG_AW +: REG_AW] == hz.rs1_e)
                hz.fwd_a_e = SEL_W'(k + 1);
            if (hz.fwd_we[k] && hz.rs2_e != '0 && hz.fwd_rd[k*REG_AW +: REG_AW] == hz.rs2_e)
                hz.fwd_b_e = SEL_W'(k + 1);
        end
    end

    // Issue is held off by mem_stall (the E instr is not really accepted), but a
    // completing writeback always retires. Set wins over clear on the same register.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (hz.long_issue_e && !hz.mem_stall && hz.rd_e != '0)
            set_vec = NUM_REGS'(1) << hz.rd_e;
        if (hz.long_done)
            clr_vec = NUM_REGS'(1) << hz.long_rd;
        pending_nxt    = (pending & ~clr_vec) | set_vec;
        pending_nxt[0] = 1'b0;
    end

    assign lu = hz.mem_read_e && hz.rd_e != '0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    assign sb = pending[hz.rs1_d] || pending[hz.rs2_d];
    assign fw = flush_cnt != '0;
    assign hz.sb_busy = |pending;

    // The redirect cycle itself is the first flush cycle, so the counter only
    // covers the remaining FLUSH_CYCLES-1 cycles. Inside the window D holds
    // wrong-path instructions, so their load-use/scoreboard hazards are ignored.
    always_comb begin
        hz.stall_f    = 1'b0;
        hz.stall_d    = 1'b0;
        hz.flush_d    = 1'b0;
        hz.flush_e    = 1'b0;
        flush_cnt_nxt = flush_cnt;
        if (hz.mem_stall) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
        end else if (hz.redirect_e) begin
            hz.flush_d    = 1'b1;
            hz.flush_e    = 1'b1;
            flush_cnt_nxt = CNT_LOAD;
        end else if (fw) begin
            hz.flush_d    = 1'b1;
            flush_cnt_nxt = flush_cnt - 1'b1;
        end else if (lu || sb) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            flush_cnt <= '0;
        end else begin
            pending   <= pending_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_stall;
    logic lu_stall_q;

    assign lu_stall = !hz.mem_stall && !hz.redirect_e && !fw && lu;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_stall_q         <= 1'b0;
            hz.perf_stall_cyc  <= '0;
            hz.perf_lu_evt     <= '0;
            hz.perf_flush_evt  <= '0;
        end else begin
            lu_stall_q <= lu_stall;
            if (hz.stall_d && hz.perf_stall_cyc != '1)
                hz.perf_stall_cyc <= hz.perf_stall_cyc + 1'b1;
            if (lu_stall && !lu_stall_q && hz.perf_lu_evt != '1)
                hz.perf_lu_evt <= hz.perf_lu_evt + 1'b1;
            if (hz.redirect_e && hz.perf_flush_evt != '1)
                hz.perf_flush_evt <= hz.perf_flush_evt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb/tb_hazard_ctrl_sb.sv - self-checking bench for hazard_ctrl_sb
module tb_hazard_ctrl_sb;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int FC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_sb_if #(.REG_AW(AW), .FWD_STAGES(NS)) hz ();

    hazard_ctrl_sb #(.REG_AW(AW), .FWD_STAGES(NS), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    // Model state: which registers await a long-latency result, and how many
    // more wrong-path cycles follow the current one.
    bit [31:0] m_pend = '0;
    int        m_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_fwd(input logic [AW-1:0] rs);
        if (rs == 0) return 0;
        for (int k = 0; k < NS; k++)
            if (hz.fwd_we[k] && hz.fwd_rd[k*AW +: AW] == rs) return k + 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = '0;
            m_left = 0;
        end else begin
            if (!hz.mem_stall) begin
                if (hz.redirect_e) m_left = FC - 1;
                else if (m_left > 0) m_left = m_left - 1;
            end
            if (hz.long_done) m_pend[hz.long_rd] = 1'b0;
            if (hz.long_issue_e && !hz.mem_stall && hz.rd_e != 0) m_pend[hz.rd_e] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit lu, sbh;
            bit e_sf, e_sd, e_fd, e_fe;
            lu  = hz.mem_read_e && hz.rd_e != 0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
            sbh = m_pend[hz.rs1_d] || m_pend[hz.rs2_d];
            {e_sf, e_sd, e_fd, e_fe} = 4'b0000;
            if (hz.mem_stall)       {e_sf, e_sd, e_fd, e_fe} = 4'b1100;
            else if (hz.redirect_e) {e_sf, e_sd, e_fd, e_fe} = 4'b0011;
            else if (m_left > 0)    {e_sf, e_sd, e_fd, e_fe} = 4'b0010;
            else if (lu || sbh)     {e_sf, e_sd, e_fd, e_fe} = 4'b1101;
            chk("m_fwd_a", 32'(hz.fwd_a_e), exp_fwd(hz.rs1_e));
            chk("m_fwd_b", 32'(hz.fwd_b_e), exp_fwd(hz.rs2_e));
            chk("m_stall_f", 32'(hz.stall_f), 32'(e_sf));
            chk("m_stall_d", 32'(hz.stall_d), 32'(e_sd));
            chk("m_flush_d", 32'(hz.flush_d), 32'(e_fd));
            chk("m_flush_e", 32'(hz.flush_e), 32'(e_fe));
            chk("m_sb_busy", 32'(hz.sb_busy), 32'(m_pend != 0));
        end
    end

    task automatic clr_in();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0; hz.rd_e = '0;
        hz.mem_read_e = 1'b0; hz.fwd_rd = '0; hz.fwd_we = '0;
        hz.long_issue_e = 1'b0; hz.long_done = 1'b0; hz.long_rd = '0;
        hz.redirect_e = 1'b0; hz.mem_stall = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst_n = 1'b0;
        step();
        check_en = 1'b1;
        look();
        chk("rst_stall_d", 32'(hz.stall_d), 0);
        chk("rst_flush_d", 32'(hz.flush_d), 0);
        chk("rst_sb_busy", 32'(hz.sb_busy), 0);
        step();
        rst_n = 1'b1;

        // Forwarding priority
        step(); hz.fwd_we = 2'b11; hz.fwd_rd = {5'd5, 5'd5}; hz.rs1_e = 5'd5; look();
        chk("fwd_youngest", 32'(hz.fwd_a_e), 1);
        step(); hz.fwd_we = 2'b10; hz.fwd_rd = {5'd5, 5'd5}; hz.rs1_e = 5'd5; look();
        chk("fwd_stage1", 32'(hz.fwd_a_e), 2);
        step(); hz.fwd_we = 2'b11; hz.fwd_rd = {5'd3, 5'd4}; hz.rs1_e = 5'd4; hz.rs2_e = 5'd3; look();
        chk("fwd_a_m", 32'(hz.fwd_a_e), 1);
        chk("fwd_b_w", 32'(hz.fwd_b_e), 2);
        step(); hz.fwd_we = 2'b11; hz.fwd_rd = '0; hz.rs1_e = '0; look();
        chk("fwd_x0", 32'(hz.fwd_a_e), 0);

        // Load-use
        step(); hz.mem_read_e = 1'b1; hz.rd_e = 5'd7; hz.rs2_d = 5'd7; look();
        chk("lu_stall_f", 32'(hz.stall_f), 1);
        chk("lu_stall_d", 32'(hz.stall_d), 1);
        chk("lu_flush_e", 32'(hz.flush_e), 1);
        step(); hz.mem_read_e = 1'b1; hz.rd_e = '0; hz.rs2_d = '0; look();
        chk("lu_x0_nostall", 32'(hz.stall_d), 0);

        // Scoreboard
        step(); hz.long_issue_e = 1'b1; hz.rd_e = 5'd9; look();
        chk("sb_issue_busy0", 32'(hz.sb_busy), 0);
        step(); hz.rs1_d = 5'd9; look();
        chk("sb_stall", 32'(hz.stall_d), 1);
        chk("sb_busy1", 32'(hz.sb_busy), 1);
        step(); hz.rs1_d = 5'd9; look();
        step(); hz.rs1_d = 5'd9; hz.long_done = 1'b1; hz.long_rd = 5'd9; look();
        chk("sb_stall_done_cyc", 32'(hz.stall_d), 1);
        step(); hz.rs1_d = 5'd9; look();
        chk("sb_release", 32'(hz.stall_d), 0);
        chk("sb_busy0", 32'(hz.sb_busy), 0);

        // Set and clear of the same register in one cycle keeps it pending
        step(); hz.long_issue_e = 1'b1; hz.rd_e = 5'd12;
        step(); hz.long_issue_e = 1'b1; hz.rd_e = 5'd12; hz.long_done = 1'b1; hz.long_rd = 5'd12;
        step(); hz.rs2_d = 5'd12; look();
        chk("sb_setclr_stall", 32'(hz.stall_d), 1);
        step(); hz.long_done = 1'b1; hz.long_rd = 5'd12;
        step(); look();
        chk("sb_setclr_busy0", 32'(hz.sb_busy), 0);

        // Issue under mem_stall does not mark the register
        step(); hz.long_issue_e = 1'b1; hz.rd_e = 5'd15; hz.mem_stall = 1'b1;
        step(); hz.rs1_d = 5'd15; look();
        chk("sb_memstall_noset", 32'(hz.sb_busy), 0);

        // Redirect window with load-use inside it
        step(); hz.redirect_e = 1'b1; look();
        chk("rd_flush_d0", 32'(hz.flush_d), 1);
        chk("rd_flush_e0", 32'(hz.flush_e), 1);
        for (int i = 0; i < 2; i++) begin
            step(); hz.mem_read_e = 1'b1; hz.rd_e = 5'd4; hz.rs1_d = 5'd4; look();
            chk("rd_win_flush_d", 32'(hz.flush_d), 1);
            chk("rd_win_flush_e", 32'(hz.flush_e), 0);
            chk("rd_win_lu_ign", 32'(hz.stall_d), 0);
        end
        step(); hz.mem_read_e = 1'b1; hz.rd_e = 5'd4; hz.rs1_d = 5'd4; look();
        chk("rd_win_end", 32'(hz.flush_d), 0);
        chk("rd_win_end_lu", 32'(hz.stall_d), 1);

        // Re-redirect inside the window reloads it
        step(); hz.redirect_e = 1'b1;
        step();
        step(); hz.redirect_e = 1'b1;
        step(); step(); look();
        chk("rd_reload", 32'(hz.flush_d), 1);
        step(); look();
        chk("rd_reload_end", 32'(hz.flush_d), 0);

        // mem_stall dominates redirect and load-use
        step(); hz.mem_stall = 1'b1; hz.redirect_e = 1'b1; hz.mem_read_e = 1'b1;
        hz.rd_e = 5'd7; hz.rs1_d = 5'd7; look();
        chk("ms_stall_f", 32'(hz.stall_f), 1);
        chk("ms_stall_d", 32'(hz.stall_d), 1);
        chk("ms_flush_d", 32'(hz.flush_d), 0);
        chk("ms_flush_e", 32'(hz.flush_e), 0);
        step(); look();
        chk("ms_no_load", 32'(hz.flush_d), 0);

        // mem_stall freezes an open window
        step(); hz.redirect_e = 1'b1;
        step(); hz.mem_stall = 1'b1; look();
        chk("ms_freeze_fd", 32'(hz.flush_d), 0);
        step(); look();
        chk("ms_freeze_w1", 32'(hz.flush_d), 1);
        step(); look();
        chk("ms_freeze_w2", 32'(hz.flush_d), 1);
        step(); look();
        chk("ms_freeze_end", 32'(hz.flush_d), 0);

        // Reset in the middle of a window with a pending register
        step(); hz.long_issue_e = 1'b1; hz.rd_e = 5'd9;
        step(); hz.redirect_e = 1'b1;
        step(); look();
        chk("rst_mid_fd", 32'(hz.flush_d), 1);
        chk("rst_mid_busy", 32'(hz.sb_busy), 1);
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1; hz.rs1_d = 5'd9; look();
        chk("rst_after_fd", 32'(hz.flush_d), 0);
        chk("rst_after_busy", 32'(hz.sb_busy), 0);
        chk("rst_after_stall", 32'(hz.stall_d), 0);

        step(); step();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
